// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART CPU register interface: register address
// map, IIR codes, LSR/IER bit positions, CFG register layout and reset value,
// and the legal frame data-length window.
// ---------------------------------------------------------------------------
package uart_pkg;

   // Register addresses
   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_IER   = 3'd1;
   localparam logic [2:0] ADDR_IIR   = 3'd2;
   localparam logic [2:0] ADDR_CFG   = 3'd3;
   localparam logic [2:0] ADDR_BAUD0 = 3'd4;
   localparam logic [2:0] ADDR_BAUD1 = 3'd5;
   localparam logic [2:0] ADDR_BAUD2 = 3'd6;
   localparam logic [2:0] ADDR_LSR   = 3'd7;

   // Interrupt identification codes, highest priority first
   localparam logic [7:0] IIR_LS   = 8'h06;
   localparam logic [7:0] IIR_RX   = 8'h04;
   localparam logic [7:0] IIR_TE   = 8'h02;
   localparam logic [7:0] IIR_NONE = 8'h01;

   // LSR bit indices
   localparam int unsigned LSR_RX_RDY   = 32'd0;
   localparam int unsigned LSR_TX_OVF   = 32'd1;
   localparam int unsigned LSR_P_ERR    = 32'd2;
   localparam int unsigned LSR_ST_ERR   = 32'd3;
   localparam int unsigned LSR_TX_FULL  = 32'd4;
   localparam int unsigned LSR_TX_EMPTY = 32'd5;
   localparam int unsigned LSR_TX_IDLE  = 32'd6;
   localparam int unsigned LSR_RX_WORK  = 32'd7;

   // IER bit indices
   localparam int unsigned IER_RX = 32'd0;
   localparam int unsigned IER_TE = 32'd1;
   localparam int unsigned IER_LS = 32'd2;

   // Legal frame data-length window
   localparam logic [3:0] DLEN_MIN = 4'd5;
   localparam logic [3:0] DLEN_MAX = 4'd8;

   // CFG register fields in bit order [6:0]
   typedef struct packed {
      logic       st_check;
      logic       parity;
      logic       check;
      logic [3:0] data_length;
   } cfg_t;

   localparam cfg_t CFG_RST = '{st_check: 1'b0, parity: 1'b0, check: 1'b0,
                                data_length: 4'd8};

   // True when a requested data length is one the core supports
   function automatic logic dlen_ok(input logic [3:0] len);
      return (len >= DLEN_MIN) && (len <= DLEN_MAX);
   endfunction

endpackage

// File: rtl/uart_irq_gen.sv
// ---------------------------------------------------------------------------
// uart_irq_gen
// Prioritised interrupt encoder. Produces the combinational IIR code from the
// enabled sources (line status > rx data > tx empty) and a registered irq.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ier[2:0]          interrupt enables {ls, te, rx}
//   rx_rdy            RX FIFO holds data
//   tx_empty          TX FIFO count is zero
//   tx_ovf            sticky TX overflow flag
//   p_error, st_error core error flags
//   iir[7:0]          current interrupt identification code (combinational)
//   irq               registered interrupt request
// ---------------------------------------------------------------------------
module uart_irq_gen
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] ier,
   input  logic       rx_rdy,
   input  logic       tx_empty,
   input  logic       tx_ovf,
   input  logic       p_error,
   input  logic       st_error,
   output logic [7:0] iir,
   output logic       irq
);

   logic src_ls;
   logic src_rx;
   logic src_te;
   logic irq_d;
   logic irq_q;

   assign src_ls = ier[IER_LS] & (p_error | st_error | tx_ovf);
   assign src_rx = ier[IER_RX] & rx_rdy;
   assign src_te = ier[IER_TE] & tx_empty;

   // Priority encode the active sources into the IIR code
   always_comb begin
      iir = IIR_NONE;
      if (src_ls) begin
         iir = IIR_LS;
      end else if (src_rx) begin
         iir = IIR_RX;
      end else if (src_te) begin
         iir = IIR_TE;
      end else begin
         iir = IIR_NONE;
      end
      irq_d = (iir != IIR_NONE);
   end

   // Interrupt request register
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: rtl/uart_reg_if.sv
// ---------------------------------------------------------------------------
// uart_reg_if
// CPU-side register interface for the UART core. Decodes an 8-bit single-cycle
// bus into DATA/IER/IIR-ACK/CFG/BAUD0-2/LSR registers and drives the core's
// control inputs.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   addr, wr_en, rd_en, wdata bus request (sampled while bus_ready=1)
//   rdata, rdata_valid        registered read response
//   bus_ready                 low for the cycle after an accepted DATA access
//   irq                       registered interrupt request
//   uart_buad, data_length, check, parity, st_check   core configuration
//   tx_in_data, tx_fifo_write, rx_fifo_read           FIFO push/pop
//   p_error_ack, st_error_ack                         error acknowledges
//   data_to_reg, rx/tx_fifo_cnt, rx_fifo_empty, tx_fifo_full,
//   rx_work, tx_work, p_error, st_error                core status
// ---------------------------------------------------------------------------
module uart_reg_if
   import uart_pkg::*;
#(
   parameter int          CLK_FREQ = 50_000_000,
   parameter logic [19:0] BAUD_RST = 20'd115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  addr,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   output logic        bus_ready,
   output logic        irq,
   output logic [19:0] uart_buad,
   output logic [3:0]  data_length,
   output logic        check,
   output logic        parity,
   output logic        st_check,
   output logic [7:0]  tx_in_data,
   output logic        tx_fifo_write,
   output logic        rx_fifo_read,
   output logic        p_error_ack,
   output logic        st_error_ack,
   input  logic [7:0]  data_to_reg,
   input  logic [4:0]  rx_fifo_cnt,
   input  logic [4:0]  tx_fifo_cnt,
   input  logic        rx_fifo_empty,
   input  logic        tx_fifo_full,
   input  logic        rx_work,
   input  logic        tx_work,
   input  logic        p_error,
   input  logic        st_error
);

   cfg_t        cfg_d, cfg_q;
   logic [2:0]  ier_d, ier_q;
   logic [19:0] baud_d, baud_q;
   logic [7:0]  sh0_d, sh0_q;
   logic [7:0]  sh1_d, sh1_q;
   logic        ovf_d, ovf_q;
   logic [7:0]  rdata_d, rdata_q;
   logic        rdata_valid_d, rdata_valid_q;
   logic        bus_ready_d, bus_ready_q;
   logic [7:0]  tx_in_data_d, tx_in_data_q;
   logic        tx_fifo_write_d, tx_fifo_write_q;
   logic        rx_fifo_read_d, rx_fifo_read_q;
   logic        p_ack_d, p_ack_q;
   logic        st_ack_d, st_ack_q;

   logic        wr_acc;
   logic        rd_acc;
   logic        tx_empty;
   logic [7:0]  lsr;
   logic [7:0]  iir;
   logic [7:0]  rd_mux;

   // RX occupancy and the clock frequency are not needed by this block
   logic        unused_ok;
   assign unused_ok = ^{rx_fifo_cnt, CLK_FREQ};

   // A write wins over a simultaneous read; nothing is accepted while stalled
   assign wr_acc   = bus_ready_q & wr_en;
   assign rd_acc   = bus_ready_q & rd_en & ~wr_en;
   assign tx_empty = (tx_fifo_cnt == 5'd0);

   assign lsr = {rx_work, tx_empty & ~tx_work, tx_empty, tx_fifo_full,
                 st_error, p_error, ovf_q, ~rx_fifo_empty};

   uart_irq_gen u_irq_gen (
      .clk      (clk),
      .rst      (rst),
      .ier      (ier_q),
      .rx_rdy   (lsr[LSR_RX_RDY]),
      .tx_empty (lsr[LSR_TX_EMPTY]),
      .tx_ovf   (lsr[LSR_TX_OVF]),
      .p_error  (p_error),
      .st_error (st_error),
      .iir      (iir),
      .irq      (irq)
   );

   // Read data multiplexer
   always_comb begin
      rd_mux = 8'h00;
      case (addr)
         ADDR_DATA:  rd_mux = rx_fifo_empty ? 8'h00 : data_to_reg;
         ADDR_IER:   rd_mux = {5'b00000, ier_q};
         ADDR_IIR:   rd_mux = iir;
         ADDR_CFG:   rd_mux = {1'b0, cfg_q};
         ADDR_BAUD0: rd_mux = baud_q[7:0];
         ADDR_BAUD1: rd_mux = baud_q[15:8];
         ADDR_BAUD2: rd_mux = {4'b0000, baud_q[19:16]};
         ADDR_LSR:   rd_mux = lsr;
         default:    rd_mux = 8'h00;
      endcase
   end

   // Bus decode: register updates, read response and pulse generation
   always_comb begin
      cfg_d           = cfg_q;
      ier_d           = ier_q;
      baud_d          = baud_q;
      sh0_d           = sh0_q;
      sh1_d           = sh1_q;
      ovf_d           = ovf_q;
      rdata_d         = rdata_q;
      rdata_valid_d   = 1'b0;
      bus_ready_d     = 1'b1;
      tx_in_data_d    = tx_in_data_q;
      tx_fifo_write_d = 1'b0;
      rx_fifo_read_d  = 1'b0;
      p_ack_d         = 1'b0;
      st_ack_d        = 1'b0;

      if (wr_acc) begin
         case (addr)
            ADDR_DATA: begin
               // Stall one cycle so the FIFO flags reflect this push
               bus_ready_d = 1'b0;
               if (!tx_fifo_full) begin
                  tx_fifo_write_d = 1'b1;
                  tx_in_data_d    = wdata;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            ADDR_IER: ier_d = wdata[2:0];
            ADDR_IIR: begin
               // Suppress a second ack on consecutive ACK writes
               p_ack_d  = wdata[2] & ~p_ack_q;
               st_ack_d = wdata[3] & ~st_ack_q;
            end
            ADDR_CFG: begin
               cfg_d.check    = wdata[4];
               cfg_d.parity   = wdata[5];
               cfg_d.st_check = wdata[6];
               if (dlen_ok(wdata[3:0])) begin
                  cfg_d.data_length = wdata[3:0];
               end else begin
                  cfg_d.data_length = cfg_q.data_length;
               end
            end
            ADDR_BAUD0: sh0_d = wdata;
            ADDR_BAUD1: sh1_d = wdata;
            ADDR_BAUD2: baud_d = {wdata[3:0], sh1_q, sh0_q};
            default:    ovf_d = ovf_q;
         endcase
      end else if (rd_acc) begin
         rdata_valid_d = 1'b1;
         rdata_d       = rd_mux;
         case (addr)
            ADDR_DATA: begin
               bus_ready_d    = 1'b0;
               rx_fifo_read_d = ~rx_fifo_empty;
            end
            ADDR_LSR: ovf_d = 1'b0;
            default:  ovf_d = ovf_q;
         endcase
      end else begin
         rdata_valid_d = 1'b0;
      end
   end

   // Register state
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q           <= CFG_RST;
         ier_q           <= 3'b000;
         baud_q          <= BAUD_RST;
         sh0_q           <= BAUD_RST[7:0];
         sh1_q           <= BAUD_RST[15:8];
         ovf_q           <= 1'b0;
         rdata_q         <= 8'h00;
         rdata_valid_q   <= 1'b0;
         bus_ready_q     <= 1'b1;
         tx_in_data_q    <= 8'h00;
         tx_fifo_write_q <= 1'b0;
         rx_fifo_read_q  <= 1'b0;
         p_ack_q         <= 1'b0;
         st_ack_q        <= 1'b0;
      end else begin
         cfg_q           <= cfg_d;
         ier_q           <= ier_d;
         baud_q          <= baud_d;
         sh0_q           <= sh0_d;
         sh1_q           <= sh1_d;
         ovf_q           <= ovf_d;
         rdata_q         <= rdata_d;
         rdata_valid_q   <= rdata_valid_d;
         bus_ready_q     <= bus_ready_d;
         tx_in_data_q    <= tx_in_data_d;
         tx_fifo_write_q <= tx_fifo_write_d;
         rx_fifo_read_q  <= rx_fifo_read_d;
         p_ack_q         <= p_ack_d;
         st_ack_q        <= st_ack_d;
      end
   end

   assign rdata         = rdata_q;
   assign rdata_valid   = rdata_valid_q;
   assign bus_ready     = bus_ready_q;
   assign uart_buad     = baud_q;
   assign data_length   = cfg_q.data_length;
   assign check         = cfg_q.check;
   assign parity        = cfg_q.parity;
   assign st_check      = cfg_q.st_check;
   assign tx_in_data    = tx_in_data_q;
   assign tx_fifo_write = tx_fifo_write_q;
   assign rx_fifo_read  = rx_fifo_read_q;
   assign p_error_ack   = p_ack_q;
   assign st_error_ack  = st_ack_q;

endmodule

// File: tb/tb_uart_reg_if.sv
// ---------------------------------------------------------------------------
// tb_uart_reg_if
// Directed bench for uart_reg_if. Reads push their expected response into a
// scoreboard queue; a monitor pops and compares on every rdata_valid.
// ---------------------------------------------------------------------------
module tb_uart_reg_if;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  addr = 3'd0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        bus_ready;
   logic        irq;
   logic [19:0] uart_buad;
   logic [3:0]  data_length;
   logic        check, parity, st_check;
   logic [7:0]  tx_in_data;
   logic        tx_fifo_write, rx_fifo_read;
   logic        p_error_ack, st_error_ack;
   logic [7:0]  data_to_reg = 8'h00;
   logic [4:0]  rx_fifo_cnt = 5'd0;
   logic [4:0]  tx_fifo_cnt = 5'd0;
   logic        rx_fifo_empty = 1'b1;
   logic        tx_fifo_full = 1'b0;
   logic        rx_work = 1'b0;
   logic        tx_work = 1'b0;
   logic        p_error = 1'b0;
   logic        st_error = 1'b0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [7:0] data;
      logic       pop;
   } exp_t;
   exp_t sb_q[$];

   uart_reg_if #(.CLK_FREQ(50_000_000), .BAUD_RST(20'd115200)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
      .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
      .bus_ready(bus_ready), .irq(irq), .uart_buad(uart_buad),
      .data_length(data_length), .check(check), .parity(parity),
      .st_check(st_check), .tx_in_data(tx_in_data),
      .tx_fifo_write(tx_fifo_write), .rx_fifo_read(rx_fifo_read),
      .p_error_ack(p_error_ack), .st_error_ack(st_error_ack),
      .data_to_reg(data_to_reg), .rx_fifo_cnt(rx_fifo_cnt),
      .tx_fifo_cnt(tx_fifo_cnt), .rx_fifo_empty(rx_fifo_empty),
      .tx_fifo_full(tx_fifo_full), .rx_work(rx_work), .tx_work(tx_work),
      .p_error(p_error), .st_error(st_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every read response must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && rdata_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rdata_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, "_rdata"}, {24'd0, rdata}, {24'd0, e.data});
            chk({e.name, "_pop"}, {31'd0, rx_fifo_read}, {31'd0, e.pop});
         end
      end
   end

   // All bus tasks start and end at a falling edge with strobes low
   task automatic wait_ready();
      int n = 0;
      while (!bus_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus_ready) chk("bus_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      wait_ready();
      addr = a; wdata = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input string name, input logic [2:0] a,
                           input logic [7:0] exp, input logic pop);
      exp_t e;
      wait_ready();
      e.name = name; e.data = exp; e.pop = pop;
      sb_q.push_back(e);
      addr = a; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_baud", {12'd0, uart_buad}, 32'd115200);
      chk("rst_dlen", {28'd0, data_length}, 32'd8);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_ready", {31'd0, bus_ready}, 32'd1);
      chk("rst_txw", {31'd0, tx_fifo_write}, 32'd0);
      chk("rst_txd", {24'd0, tx_in_data}, 32'd0);
      bus_read("rst_iir", 3'd2, 8'h01, 1'b0);

      // Baud staging
      bus_write(3'd4, 8'h00);
      bus_write(3'd5, 8'hC2);
      chk("baud_hold0", {12'd0, uart_buad}, 32'd115200);
      bus_write(3'd6, 8'h01);
      chk("baud_commit0", {12'd0, uart_buad}, 32'h1C200);
      bus_write(3'd4, 8'h34);
      bus_write(3'd5, 8'h12);
      chk("baud_hold1", {12'd0, uart_buad}, 32'h1C200);
      bus_write(3'd6, 8'h0F);
      chk("baud_commit1", {12'd0, uart_buad}, 32'hF1234);
      bus_read("rd_baud0", 3'd4, 8'h34, 1'b0);
      bus_read("rd_baud1", 3'd5, 8'h12, 1'b0);
      bus_read("rd_baud2", 3'd6, 8'h0F, 1'b0);

      // CFG: data length only accepted inside 5..8
      bus_write(3'd3, 8'h0B);
      chk("cfg_dlen_keep8", {28'd0, data_length}, 32'd8);
      bus_read("rd_cfg0b", 3'd3, 8'h08, 1'b0);
      bus_write(3'd3, 8'h75);
      chk("cfg_dlen5", {28'd0, data_length}, 32'd5);
      chk("cfg_flags", {29'd0, st_check, parity, check}, 32'd7);
      bus_read("rd_cfg75", 3'd3, 8'h75, 1'b0);
      bus_write(3'd3, 8'h80);
      chk("cfg_dlen_keep5", {28'd0, data_length}, 32'd5);
      bus_read("rd_cfg80", 3'd3, 8'h05, 1'b0);

      // DATA write, FIFO not full
      bus_write(3'd0, 8'hA5);
      chk("push_pulse", {31'd0, tx_fifo_write}, 32'd1);
      chk("push_data", {24'd0, tx_in_data}, 32'hA5);
      chk("push_stall", {31'd0, bus_ready}, 32'd0);
      @(negedge clk);
      chk("push_pulse_end", {31'd0, tx_fifo_write}, 32'd0);
      chk("push_ready_back", {31'd0, bus_ready}, 32'd1);

      // DATA write, FIFO full -> overflow
      tx_fifo_full = 1'b1; tx_fifo_cnt = 5'd16; tx_work = 1'b1;
      bus_write(3'd0, 8'h5A);
      chk("full_no_push", {31'd0, tx_fifo_write}, 32'd0);
      chk("full_data_kept", {24'd0, tx_in_data}, 32'hA5);
      bus_read("lsr_ovf_set", 3'd7, 8'h12, 1'b0);
      bus_read("lsr_ovf_clr", 3'd7, 8'h10, 1'b0);
      tx_fifo_full = 1'b0; tx_fifo_cnt = 5'd0; tx_work = 1'b0;

      // DATA reads
      rx_fifo_empty = 1'b0; data_to_reg = 8'h3C;
      bus_read("rx_pop", 3'd0, 8'h3C, 1'b1);
      chk("rx_stall", {31'd0, bus_ready}, 32'd0);
      rx_fifo_empty = 1'b1;
      bus_read("rx_empty", 3'd0, 8'h00, 1'b0);

      // Interrupts
      rx_fifo_empty = 1'b0; p_error = 1'b1;
      bus_write(3'd1, 8'hFF);
      bus_read("rd_ier", 3'd1, 8'h07, 1'b0);
      bus_read("iir_ls", 3'd2, 8'h06, 1'b0);
      chk("irq_ls", {31'd0, irq}, 32'd1);
      bus_write(3'd2, 8'h04);
      chk("p_ack_pulse", {30'd0, p_error_ack, st_error_ack}, 32'd2);
      @(negedge clk);
      chk("p_ack_end", {31'd0, p_error_ack}, 32'd0);
      bus_write(3'd2, 8'h08);
      chk("st_ack_pulse", {30'd0, p_error_ack, st_error_ack}, 32'd1);
      p_error = 1'b0;
      bus_read("iir_rx", 3'd2, 8'h04, 1'b0);
      rx_fifo_empty = 1'b1;
      bus_read("iir_te", 3'd2, 8'h02, 1'b0);
      tx_fifo_cnt = 5'd3;
      bus_read("iir_none", 3'd2, 8'h01, 1'b0);
      @(negedge clk);
      chk("irq_clear", {31'd0, irq}, 32'd0);

      // Simultaneous write+read on DATA; then a strobe while stalled
      rx_fifo_empty = 1'b0; data_to_reg = 8'h66;
      wait_ready();
      addr = 3'd0; wdata = 8'h77; wr_en = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("wr_rd_push", {31'd0, tx_fifo_write}, 32'd1);
      chk("wr_rd_no_pop", {31'd0, rx_fifo_read}, 32'd0);
      chk("wr_rd_data", {24'd0, tx_in_data}, 32'h77);
      wdata = 8'h99;
      @(negedge clk);
      wr_en = 1'b0;
      chk("stall_no_push", {31'd0, tx_fifo_write}, 32'd0);
      chk("stall_no_data", {24'd0, tx_in_data}, 32'h77);
      chk("stall_ready", {31'd0, bus_ready}, 32'd1);

      // Reset mid-access cancels the pending pulse
      addr = 3'd0; wdata = 8'h11; wr_en = 1'b1; rst = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; rst = 1'b0;
      chk("rst_mid_no_push", {31'd0, tx_fifo_write}, 32'd0);
      chk("rst_mid_txd", {24'd0, tx_in_data}, 32'd0);
      chk("rst_mid_baud", {12'd0, uart_buad}, 32'd115200);
      chk("rst_mid_dlen", {28'd0, data_length}, 32'd8);

      repeat (2) @(negedge clk);
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_reg_if.md
# uart_reg_if

CPU-side register interface for the UART core. Decodes a simple 8-bit single-cycle bus into configuration, baud, data, status and acknowledge registers, and drives the UART core's control inputs: baud, frame format, FIFO push/pop, error acks. Aggregates core status into a line-status register and a prioritised interrupt. Sits directly upstream of the UART core; both are instantiated side by side in the 16550 wrapper.

## Interface
- CLK_FREQ, 50_000_000, system clock in Hz; informational only, passed through from the wrapper.
- BAUD_RST, 20'd115200, reset value of `uart_buad`.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  3  register address.
- wr_en / rd_en  in  1  single-cycle write/read strobes; sampled only when `bus_ready`=1.
- wdata  in  8  write data.
- rdata  out  8  read data, registered.
- rdata_valid  out  1  one-cycle pulse qualifying `rdata`.
- bus_ready  out  1  0 for the one cycle after an accepted DATA access.
- irq  out  1  registered interrupt request.
- uart_buad  out  20  baud rate to the core.
- data_length  out  4  frame data bits.
- check / parity / st_check  out  1  parity enable, parity select (1 = odd), stop-bit check on parity error.
- tx_in_data  out  8  TX FIFO write data.
- tx_fifo_write  out  1  TX FIFO push pulse.
- rx_fifo_read  out  1  RX FIFO pop pulse.
- p_error_ack / st_error_ack  out  1  one-cycle error acknowledges.
- data_to_reg  in  8  head of RX FIFO; valid while `rx_fifo_empty`=0 (show-ahead).
- rx_fifo_cnt / tx_fifo_cnt  in  5  FIFO occupancy, 0..16.
- rx_fifo_empty / tx_fifo_full / rx_work / tx_work / p_error / st_error  in  1  core status.

## Operation
- Register map:
  - 0 DATA: write pushes to TX FIFO; read pops from RX FIFO.
  - 1 IER: [2:0] = line-status, tx-empty, rx-data enables; [7:3] read 0.
  - 2 IIR (read) / ACK (write).
  - 3 CFG: [3:0] data_length, [4] check, [5] parity, [6] st_check, [7] reserved, reads 0.
  - 4/5/6 BAUD0/1/2: baud bytes; BAUD2 uses [3:0] only.
  - 7 LSR: read-only.
- CFG write: `data_length` updates only if wdata[3:0] is 5..8; otherwise it keeps its value. The other fields always update.
- Baud staging: BAUD0 and BAUD1 writes go to shadow registers. A BAUD2 write commits {wdata[3:0], shadow1, shadow0} to `uart_buad` atomically. Reads return the committed value.
- DATA write:
  - If `tx_fifo_full`=0: the next cycle has `tx_in_data`=wdata and `tx_fifo_write`=1.
  - If `tx_fifo_full`=1: the byte is dropped and sticky LSR[1] (tx overflow) is set.
- DATA read:
  - If `rx_fifo_empty`=0: `rdata` captures `data_to_reg`, and `rx_fifo_read`=1 in the same cycle as `rdata_valid`.
  - If `rx_fifo_empty`=1: `rdata`=0x00 and there is no pop.
- ACK write: wdata[2] pulses `p_error_ack` and wdata[3] pulses `st_error_ack`, each one cycle.
- LSR bits:
  - [0] !rx_fifo_empty
  - [1] tx overflow, sticky; cleared by an LSR read
  - [2] p_error
  - [3] st_error
  - [4] tx_fifo_full
  - [5] tx_fifo_cnt==0
  - [6] tx_fifo_cnt==0 && !tx_work
  - [7] rx_work
- Interrupt sources:
  - ls = IER[2] & (p_error|st_error|LSR[1])
  - rx = IER[0] & LSR[0]
  - te = IER[1] & LSR[5]
- IIR priority: ls gives 0x06, else rx 0x04, else te 0x02, else 0x01. `irq` = (IIR != 0x01).
- Simultaneous `wr_en` and `rd_en`: the write executes and the read is ignored (no `rdata_valid`).
- Any strobe while `bus_ready`=0 is ignored entirely.

## Timing
- Read latency: 1 cycle. `rdata` and `rdata_valid` are registered from the `rd_en` cycle.
- Writes take effect on the register outputs the cycle after `wr_en`.
- `tx_fifo_write`, `rx_fifo_read` and the acks are one-cycle pulses, registered, never asserted twice back-to-back.
- `bus_ready`=0 exactly the cycle after an accepted DATA read or write, so FIFO counts and flags settle before the next access.
- `irq` is registered: 1 cycle after its source changes.
- Reset values:
  - `uart_buad`=BAUD_RST, shadows=BAUD_RST bytes
  - `data_length`=8, `check`=`parity`=`st_check`=0
  - IER=0, LSR[1]=0
  - `rdata`=0, `rdata_valid`=0, `bus_ready`=1, `irq`=0, all pulses 0, `tx_in_data`=0
- Reset mid-access cancels any pending pulse.

## Structure
- Shared package `uart_pkg`: address constants (ADDR_DATA..ADDR_LSR), IIR codes, LSR bit indices, CFG reset default, data-length bounds 5/8.
- One sub-module, `uart_irq_gen`: combinational priority encoder producing IIR plus a registered `irq`.
- Everything else (decode, CFG/IER/baud registers, pulse generation, `bus_ready`) lives in the top file.

## Test plan
- Reset -> `uart_buad`=115200, `data_length`=8, IIR read=0x01, `irq`=0, `bus_ready`=1.
- Write BAUD0=0x00, BAUD1=0xC2, BAUD2=0x01 -> `uart_buad` stays 115200 until the BAUD2 write, then becomes 0x1C200 on the next cycle. CFG write 0x0B -> `data_length` unchanged at 8.
- DATA write 0xA5 with `tx_fifo_full`=0 -> next cycle `tx_fifo_write`=1, `tx_in_data`=0xA5, `bus_ready`=0. Same write with `tx_fifo_full`=1 -> no pulse, LSR[1]=1; the next LSR read returns bit1=1, and the read after that returns bit1=0.
- `rx_fifo_empty`=0, `data_to_reg`=0x3C, read DATA -> 1 cycle later `rdata`=0x3C with `rdata_valid`=1 and `rx_fifo_read`=1. A read with `rx_fifo_empty`=1 -> `rdata`=0x00 and no pop.
- IER=0x07, `p_error`=1 with rx data present -> IIR=0x06 and `irq`=1. ACK write 0x04 -> one-cycle `p_error_ack`. Once `p_error` falls -> IIR=0x04.
- Simultaneous `wr_en`/`rd_en` on DATA -> push occurs, no `rdata_valid`. A strobe during `bus_ready`=0 -> no effect.
